// File: rtl/tt_ternary_pkg.sv
// Shared definitions for the ternary weight path: plane and ternary encodings,
// the unload FSM state enum and the ui_param field layout.
// Optional build macro used by the unload block: UNLOAD_SNAPSHOT_EN.
package tt_ternary_pkg;

  // Plane selector encoding carried on uo_plane
  localparam logic PLANE_MSB = 1'b0;
  localparam logic PLANE_LSB = 1'b1;

  // Ternary weight encodings (2-bit two's complement)
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_NEG  = 2'b11;

  // ui_param field layout: [2:0] last column index, [6:3] last row index
  localparam int unsigned PARAM_COL_LSB = 0;
  localparam int unsigned PARAM_COL_W   = 3;
  localparam int unsigned PARAM_ROW_LSB = 3;
  localparam int unsigned PARAM_ROW_W   = 4;
  localparam int unsigned PARAM_W       = PARAM_COL_W + PARAM_ROW_W;

  typedef struct packed {
    logic [PARAM_ROW_W-1:0] last_row;
    logic [PARAM_COL_W-1:0] last_col;
  } unload_param_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSB  = 2'd1,
    ST_LSB  = 2'd2,
    ST_HOLD = 2'd3
  } unload_state_e;

endpackage

// File: rtl/tt_plane_select.sv
// Combinational column/plane mux: picks one bit plane of one weight column,
// masking rows beyond the last row index and zeroing the word when disabled.
// Ports:
//   weights  packed array, element g = row*MAX_OUT_LEN+col at [2g+1:2g]
//   col      selected column
//   plane    PLANE_MSB selects bit 1, PLANE_LSB selects bit 0
//   last_row rows above this index read 0
//   en       word is forced to 0 when low
//   word_c   selected plane word, bit i = row i
module tt_plane_select
  import tt_ternary_pkg::*;
#(
  parameter int unsigned MAX_IN_LEN  = 16,
  parameter int unsigned MAX_OUT_LEN = 8,
  localparam int unsigned COL_W      = $clog2(MAX_OUT_LEN),
  localparam int unsigned WEIGHTS_W  = 2 * MAX_IN_LEN * MAX_OUT_LEN
) (
  input  logic [WEIGHTS_W-1:0]   weights,
  input  logic [COL_W-1:0]       col,
  input  logic                   plane,
  input  logic [PARAM_ROW_W-1:0] last_row,
  input  logic                   en,
  output logic [MAX_IN_LEN-1:0]  word_c
);

  // Reshape the flat vector into [row][col] elements
  logic [1:0] elems [MAX_IN_LEN][MAX_OUT_LEN];

  for (genvar r = 0; r < MAX_IN_LEN; r++) begin : g_row
    for (genvar c = 0; c < MAX_OUT_LEN; c++) begin : g_col
      assign elems[r][c] = weights[2*(r*MAX_OUT_LEN+c) +: 2];
    end

    logic [1:0] sel;
    logic       row_ok;
    assign sel    = elems[r][col];
    assign row_ok = (PARAM_ROW_W'(r) <= last_row);
    assign word_c[r] = en & row_ok & ((plane == PLANE_MSB) ? sel[1] : sel[0]);
  end

endmodule

// File: rtl/tt_um_unload.sv
// Readback transmitter for ternary weights. On a rising ena edge it streams
// each column as an MSB-plane word then an LSB-plane word over valid/ready,
// pulses uo_done after the last word and parks until ena falls.
// Build macro UNLOAD_SNAPSHOT_EN: copy ui_weights on the start edge and read
// from the copy; otherwise words are read live from ui_weights.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   ena         rising edge starts a dump, falling edge aborts to idle
//   ui_weights  packed 2-bit weights, element row*MAX_OUT_LEN+col
//   ui_param    [2:0] last column, [6:3] last row
//   ui_ready    downstream accepts current word
//   uo_word     current plane word (bit i = row i)
//   uo_valid    uo_word valid
//   uo_plane    0 = MSB plane, 1 = LSB plane
//   uo_done     one-cycle pulse after the final word transfers
module tt_um_unload
  import tt_ternary_pkg::*;
#(
  parameter int unsigned MAX_IN_LEN  = 16,
  parameter int unsigned MAX_OUT_LEN = 8,
  localparam int unsigned COL_W      = $clog2(MAX_OUT_LEN),
  localparam int unsigned WEIGHTS_W  = 2 * MAX_IN_LEN * MAX_OUT_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [WEIGHTS_W-1:0]  ui_weights,
  input  logic [PARAM_W-1:0]    ui_param,
  input  logic                  ui_ready,
  output logic [MAX_IN_LEN-1:0] uo_word,
  output logic                  uo_valid,
  output logic                  uo_plane,
  output logic                  uo_done
);

  unload_state_e          state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [COL_W-1:0]       last_col_q;
  logic [PARAM_ROW_W-1:0] last_row_q;
  logic                   ena_d_q;
  logic                   done_q, done_d;
  logic                   capture_c;
  logic                   start_c, abort_c;
  logic [WEIGHTS_W-1:0]   src_weights;
  unload_param_t          param_c;

  assign start_c = ena & ~ena_d_q;
  assign abort_c = ~ena & ena_d_q;
  assign param_c = unload_param_t'(ui_param);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath-next logic; abort outranks any handshake
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    done_d    = 1'b0;
    capture_c = 1'b0;
    if (abort_c) begin
      state_d = ST_IDLE;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_c) begin
          state_d   = ST_MSB;
          col_d     = '0;
          capture_c = 1'b1;
        end
        ST_MSB: if (ui_ready) state_d = ST_LSB;
        ST_LSB: if (ui_ready) begin
          if (col_q == last_col_q) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end else begin
            col_d   = COL_W'(col_q + 1'b1);
            state_d = ST_MSB;
          end
        end
        ST_HOLD: state_d = ST_HOLD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Column, edge detect, done and captured parameters; last column clamps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q      <= '0;
      ena_d_q    <= 1'b0;
      done_q     <= 1'b0;
      last_col_q <= '0;
      last_row_q <= '0;
    end else begin
      col_q   <= col_d;
      ena_d_q <= ena;
      done_q  <= done_d;
      if (capture_c) begin
        last_col_q <= (32'(param_c.last_col) >= MAX_OUT_LEN) ?
                      COL_W'(MAX_OUT_LEN - 1) : COL_W'(param_c.last_col);
        last_row_q <= param_c.last_row;
      end
    end
  end

`ifdef UNLOAD_SNAPSHOT_EN
  // Weight snapshot taken on the start edge, frozen for the whole dump
  logic [WEIGHTS_W-1:0] snap_q;
  always_ff @(posedge clk) begin
    if (!rst_n)         snap_q <= '0;
    else if (capture_c) snap_q <= ui_weights;
  end
  assign src_weights = snap_q;
`else
  assign src_weights = ui_weights;
`endif

  // Output decode from state
  always_comb begin
    uo_valid = 1'b0;
    uo_plane = PLANE_MSB;
    case (state_q)
      ST_MSB: uo_valid = 1'b1;
      ST_LSB: begin
        uo_valid = 1'b1;
        uo_plane = PLANE_LSB;
      end
      default: ;
    endcase
  end

  assign uo_done = done_q;

  tt_plane_select #(
    .MAX_IN_LEN (MAX_IN_LEN),
    .MAX_OUT_LEN(MAX_OUT_LEN)
  ) u_plane_select (
    .weights (src_weights),
    .col     (col_q),
    .plane   (uo_plane),
    .last_row(last_row_q),
    .en      (uo_valid),
    .word_c  (uo_word)
  );

endmodule
